// File: rtl/imm_packer.sv
`default_nettype none
// ============================================================================
// Module      : imm_packer
// Description : Two-stage valid/ready pipeline that packs a signed 32-bit
//               immediate into instruction bits [31:7] for the I/S/U/B/J
//               formats. It flags range, alignment and bad-format errors and
//               counts delivered results that carry an error.
// Ports       : clk, rst_n          - clock, synchronous active-low reset
//               in_valid/in_ready  - request handshake (imm, immsrc)
//               out_valid/out_ready- result handshake (field, err)
//               field[24:0]        - instruction bits [31:7], 0 on error
//               err[2:0]           - {bad format, alignment, range}
//               err_count          - saturating count of errored results
// Revision    : 1.0 - initial release
// ============================================================================
module imm_packer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      imm,
    input  logic [2:0]       immsrc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [24:0]      field,
    output logic [2:0]       err,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [2:0]       c_FMT_I   = 3'd0;
    localparam logic [2:0]       c_FMT_S   = 3'd1;
    localparam logic [2:0]       c_FMT_U   = 3'd2;
    localparam logic [2:0]       c_FMT_B   = 3'd5;
    localparam logic [2:0]       c_FMT_J   = 3'd6;
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Stage 1: captured request plus its error flags
    logic        r_s1_valid;
    logic [31:0] r_s1_imm;
    logic [2:0]  r_s1_fmt;
    logic [2:0]  r_s1_err;

    // Stage 2: packed result presented at the output
    logic             r_s2_valid;
    logic [24:0]      r_field;
    logic [2:0]       r_err;
    logic [CNT_W-1:0] r_err_count;

    logic        w_s2_adv;
    logic        w_in_fire;
    logic        w_out_fire;
    logic        w_sext_11;
    logic        w_sext_12;
    logic        w_sext_20;
    logic [2:0]  w_chk_err;
    logic [24:0] w_pack;

    assign w_s2_adv   = !r_s2_valid || out_ready;
    assign in_ready   = !r_s1_valid || w_s2_adv;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_s2_valid && out_ready;

    // The value fits the format's signed field when every bit above the
    // field's sign bit matches it (all ones or all zeros).
    assign w_sext_11 = (&imm[31:11]) || !(|imm[31:11]);
    assign w_sext_12 = (&imm[31:12]) || !(|imm[31:12]);
    assign w_sext_20 = (&imm[31:20]) || !(|imm[31:20]);

    always_comb begin
        w_chk_err = 3'b000;
        case (immsrc)
            c_FMT_I, c_FMT_S: w_chk_err[0] = !w_sext_11;
            c_FMT_U:          w_chk_err[0] = |imm[11:0];
            c_FMT_B: begin
                w_chk_err[0] = !w_sext_12;
                w_chk_err[1] = imm[0];
            end
            c_FMT_J: begin
                w_chk_err[0] = !w_sext_20;
                w_chk_err[1] = imm[0];
            end
            default:          w_chk_err[2] = 1'b1;
        endcase
    end

    // Scatter the immediate bits into their instruction positions; any
    // error suppresses the field so a bad encoding is never emitted.
    always_comb begin
        w_pack = 25'd0;
        case (r_s1_fmt)
            c_FMT_I: w_pack[24:13] = r_s1_imm[11:0];
            c_FMT_S: begin
                w_pack[24:18] = r_s1_imm[11:5];
                w_pack[4:0]   = r_s1_imm[4:0];
            end
            c_FMT_U: w_pack[24:5] = r_s1_imm[31:12];
            c_FMT_B: begin
                w_pack[24]    = r_s1_imm[12];
                w_pack[23:18] = r_s1_imm[10:5];
                w_pack[4:1]   = r_s1_imm[4:1];
                w_pack[0]     = r_s1_imm[11];
            end
            c_FMT_J: begin
                w_pack[24]    = r_s1_imm[20];
                w_pack[23:14] = r_s1_imm[10:1];
                w_pack[13]    = r_s1_imm[11];
                w_pack[12:5]  = r_s1_imm[19:12];
            end
            default: w_pack = 25'd0;
        endcase
        if (|r_s1_err) begin
            w_pack = 25'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_imm    <= 32'd0;
            r_s1_fmt    <= 3'd0;
            r_s1_err    <= 3'd0;
            r_s2_valid  <= 1'b0;
            r_field     <= 25'd0;
            r_err       <= 3'd0;
            r_err_count <= '0;
        end else begin
            if (w_in_fire) begin
                r_s1_valid <= 1'b1;
                r_s1_imm   <= imm;
                r_s1_fmt   <= immsrc;
                r_s1_err   <= w_chk_err;
            end else if (w_s2_adv) begin
                r_s1_valid <= 1'b0;
            end

            // Payload only reloads on a real S1->S2 move so an idle S2
            // never picks up stale S1 contents.
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_field <= w_pack;
                    r_err   <= r_s1_err;
                end
            end

            if (w_out_fire && (|r_err) && !(&r_err_count)) begin
                r_err_count <= r_err_count + c_CNT_ONE;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign field     = r_field;
    assign err       = r_err;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: doc/imm_packer.md
IMM_PACKER -- requirements
Module: imm_packer

Interface
REQ-001 Parameter CNT_W, default 8, width of the saturating error counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on clk rising edge.
REQ-004 in_valid  input  1  request presents imm and immsrc.
REQ-005 in_ready  output  1  block accepts a request this cycle.
REQ-006 imm  input  32  signed immediate value to encode.
REQ-007 immsrc  input  3  format: 0=I, 1=S, 2=U, 5=B, 6=J; 3, 4 and 7 are invalid.
REQ-008 out_valid  output  1  packed result available.
REQ-009 out_ready  input  1  consumer accepts the result this cycle.
REQ-010 field  output  25  instruction bits [31:7] holding the immediate; all non-immediate bits are 0.
REQ-011 err  output  3  bit0=range, bit1=alignment, bit2=bad format.
REQ-012 err_count  output  CNT_W  count of delivered results with err != 0.

Function
REQ-013 Two-stage pipeline: S1 registers the request with its checks; S2 registers the packed field and err.
REQ-014 Transfer on in_valid&&in_ready at input and on out_valid&&out_ready at output; latency from acceptance to out_valid is exactly 2 cycles when unstalled.
REQ-015 S2 advance is defined as (!S2.valid || out_ready); S1 moves into S2 when S1 is valid and S2 advance is true.
REQ-016 in_ready = !S1.valid || S2 advance; in_ready is combinational and does not depend on in_valid.
REQ-017 Sustained throughput is 1 result per cycle while out_ready=1.
REQ-018 Once out_valid=1, field, err and out_valid hold stable until out_ready=1.
REQ-019 I format: field[24:13]=imm[11:0]; range error unless imm[31:11] are all equal.
REQ-020 S format: field[24:18]=imm[11:5], field[4:0]=imm[4:0]; range check is the same as I.
REQ-021 U format: field[24:5]=imm[31:12]; range error if imm[11:0]!=0.
REQ-022 B format: field[24]=imm[12], field[23:18]=imm[10:5], field[4:1]=imm[4:1], field[0]=imm[11]; range error unless imm[31:12] are all equal; alignment error if imm[0]=1.
REQ-023 J format: field[24]=imm[20], field[23:14]=imm[10:1], field[13]=imm[11], field[12:5]=imm[19:12]; range error unless imm[31:20] are all equal; alignment error if imm[0]=1.
REQ-024 Invalid immsrc sets err[2]; range and alignment checks are not evaluated for it.
REQ-025 If any err bit is set, field is forced to 0.
REQ-026 err_count increments by 1 on each output transfer with err!=0 and saturates at all-ones.
REQ-027 Simultaneous input and output transfer in one cycle is legal; no request is lost or duplicated.

Reset
REQ-028 While rst_n=0 at a clock edge: S1.valid=0, S2.valid=0, field=0, err=0, err_count=0.
REQ-029 In the cycle after reset, out_valid=0 and in_ready=1.
REQ-030 Reset during operation discards all in-flight requests; no partial result is ever presented.
REQ-031 Inputs are ignored while rst_n=0.

Verification
REQ-032 I: imm=0xFFFFFFFF, immsrc=0, out_ready=1 -> out_valid is asserted 2 cycles after acceptance with field=0x1FFE000, err=0.
REQ-033 U: imm=0x12345000, immsrc=2 -> field=0x02468A0, err=0; then imm=0x12345001 -> field=0, err=3'b001, err_count=1.
REQ-034 B/J: imm=0x00000800, immsrc=5 -> field=0x0000001; imm=0x00100000, immsrc=6 -> err=3'b001; imm=0x00000003, immsrc=6 -> err=3'b010.
REQ-035 Backpressure: hold out_ready=0 and offer 3 back-to-back valid requests -> 2 are accepted, in_ready=0 while the third is held; release out_ready -> 3 results delivered in order, one per cycle.
REQ-036 immsrc=7 repeated 300 times with out_ready=1 -> each result has err=3'b100; err_count saturates at 255.
REQ-037 Assert rst_n=0 with both stages full -> next cycle out_valid=0, in_ready=1, err_count=0.
